// File: rtl/e203_exu_dsp_addsub_seq_if.sv
// Requester and response channels of the shared DSP adder sequencer.
// The master side is the requesters/consumer, the slave side is the sequencer.
interface e203_exu_dsp_addsub_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic                r0_valid_i;
    logic                r0_ready_o;
    logic [2*XLEN-1:0]   r0_op1_i;
    logic [2*XLEN-1:0]   r0_op2_i;
    logic                r0_sub_i;
    logic                r0_wide_i;

    logic                r1_valid_i;
    logic                r1_ready_o;
    logic [2*XLEN-1:0]   r1_op1_i;
    logic [2*XLEN-1:0]   r1_op2_i;
    logic                r1_sub_i;
    logic                r1_wide_i;

    logic                o_valid;
    logic                o_ready;
    logic [2*XLEN-1:0]   o_res;
    logic                o_ovf;
    logic                o_src;

    modport master (
        output r0_valid_i, r0_op1_i, r0_op2_i, r0_sub_i, r0_wide_i,
        output r1_valid_i, r1_op1_i, r1_op2_i, r1_sub_i, r1_wide_i,
        output o_ready,
        input  r0_ready_o, r1_ready_o,
        input  o_valid, o_res, o_ovf, o_src
    );

    modport slave (
        input  r0_valid_i, r0_op1_i, r0_op2_i, r0_sub_i, r0_wide_i,
        input  r1_valid_i, r1_op1_i, r1_op2_i, r1_sub_i, r1_wide_i,
        input  o_ready,
        output r0_ready_o, r1_ready_o,
        output o_valid, o_res, o_ovf, o_src
    );
endinterface

// File: rtl/e203_exu_dsp_addsub_seq.sv
// Round-robin sequencer for the shared EXU DSP adder: 32-bit ops in one beat,
// 64-bit ops in two (low then high with held carry), result on a valid/ready channel.
module e203_exu_dsp_addsub_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ADD_W = XLEN + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    e203_exu_dsp_addsub_seq_if.slave bus,
    output logic                 adder_en_o,
    output logic [ADD_W-1:0]     adder_op1_o,
    output logic [ADD_W-1:0]     adder_op2_o,
    output logic                 adder_cin_o,
    input  logic [ADD_W-1:0]     adder_res_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_RSP
    } state_t;

    state_t              r_state;
    logic                r_rr_ptr;
    logic                r_sub;
    logic                r_wide;
    logic                r_src;
    logic                r_carry;
    logic                r_valid;
    logic                r_ovf;
    logic [2*XLEN-1:0]   r_op1;
    logic [2*XLEN-1:0]   r_op2;
    logic [2*XLEN-1:0]   r_res;

    logic                w_any;
    logic                w_grant;
    logic                w_acc;
    logic                w_ovf;
    logic [XLEN-1:0]     w_a_half;
    logic [XLEN-1:0]     w_b_half;

    // Grant prefers the pointer-selected requester and falls back to the other one.
    always_comb begin
        w_any = bus.r0_valid_i | bus.r1_valid_i;
        if (r_rr_ptr) begin
            w_grant = bus.r1_valid_i ? 1'b1 : 1'b0;
        end else begin
            w_grant = bus.r0_valid_i ? 1'b0 : 1'b1;
        end
    end

    assign w_acc          = (r_state == S_IDLE) & ~flush_i & w_any;
    assign bus.r0_ready_o = w_acc & ~w_grant;
    assign bus.r1_ready_o = w_acc &  w_grant;

    always_comb begin
        adder_en_o  = 1'b0;
        adder_op1_o = '0;
        adder_op2_o = '0;
        adder_cin_o = 1'b0;
        w_a_half    = '0;
        w_b_half    = '0;
        unique case (r_state)
            S_LO: begin
                adder_en_o  = 1'b1;
                w_a_half    = r_op1[XLEN-1:0];
                w_b_half    = r_op2[XLEN-1:0];
                adder_cin_o = r_sub;
            end
            S_HI: begin
                adder_en_o  = 1'b1;
                w_a_half    = r_op1[2*XLEN-1:XLEN];
                w_b_half    = r_op2[2*XLEN-1:XLEN];
                adder_cin_o = r_carry;
            end
            default: ;
        endcase
        // Adder inputs stay at zero outside the beats so the shared adder is quiet.
        if (adder_en_o) begin
            adder_op1_o = {{(ADD_W-XLEN){1'b0}}, w_a_half};
            adder_op2_o = {{(ADD_W-XLEN){1'b0}}, (r_sub ? ~w_b_half : w_b_half)};
        end
    end

    assign w_ovf = (adder_op1_o[XLEN-1] == adder_op2_o[XLEN-1]) &
                   (adder_res_i[XLEN-1] != adder_op1_o[XLEN-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= 1'b0;
            r_sub    <= 1'b0;
            r_wide   <= 1'b0;
            r_src    <= 1'b0;
            r_carry  <= 1'b0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_res    <= '0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_op1    <= w_grant ? bus.r1_op1_i  : bus.r0_op1_i;
                        r_op2    <= w_grant ? bus.r1_op2_i  : bus.r0_op2_i;
                        r_sub    <= w_grant ? bus.r1_sub_i  : bus.r0_sub_i;
                        r_wide   <= w_grant ? bus.r1_wide_i : bus.r0_wide_i;
                        r_src    <= w_grant;
                        r_rr_ptr <= ~w_grant;
                        r_state  <= S_LO;
                    end
                end
                S_LO: begin
                    r_res   <= {{XLEN{1'b0}}, adder_res_i[XLEN-1:0]};
                    r_carry <= adder_res_i[XLEN];
                    r_ovf   <= w_ovf;
                    if (r_wide) begin
                        r_state <= S_HI;
                    end else begin
                        r_valid <= 1'b1;
                        r_state <= S_RSP;
                    end
                end
                S_HI: begin
                    r_res[2*XLEN-1:XLEN] <= adder_res_i[XLEN-1:0];
                    r_ovf   <= w_ovf;
                    r_valid <= 1'b1;
                    r_state <= S_RSP;
                end
                S_RSP: begin
                    if (bus.o_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_valid = r_valid;
    assign bus.o_res   = r_res;
    assign bus.o_ovf   = r_ovf;
    assign bus.o_src   = r_src;

    a_one_ready: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.r0_ready_o && bus.r1_ready_o));
    a_valid_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        bus.o_valid |-> (r_state == S_RSP));

endmodule

// File: tb/tb_e203_exu_dsp_addsub_seq.sv
// Bench for the DSP adder sequencer: an ideal adder closes the loop, and results
// are compared with signed arithmetic done at full width.
module tb_e203_exu_dsp_addsub_seq;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned ADD_W = XLEN + 1;

    typedef struct packed {
        logic [63:0] res;
        logic        ovf;
        logic        src;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush_i;
    logic              adder_en;
    logic [ADD_W-1:0]  adder_op1;
    logic [ADD_W-1:0]  adder_op2;
    logic              adder_cin;
    logic [ADD_W-1:0]  adder_res;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    e203_exu_dsp_addsub_seq_if #(.XLEN(XLEN)) bus ();

    e203_exu_dsp_addsub_seq #(.XLEN(XLEN), .ADD_W(ADD_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .bus         (bus),
        .adder_en_o  (adder_en),
        .adder_op1_o (adder_op1),
        .adder_op2_o (adder_op2),
        .adder_cin_o (adder_cin),
        .adder_res_i (adder_res)
    );

    assign adder_res = adder_op1 + adder_op2 + {{(ADD_W-1){1'b0}}, adder_cin};

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic sub, input logic wide, input logic src);
        logic signed [65:0] sa, sb, sr;
        exp_t e;
        if (wide) begin
            sa = {{2{a[63]}}, a};
            sb = {{2{b[63]}}, b};
        end else begin
            sa = {{34{a[31]}}, a[31:0]};
            sb = {{34{b[31]}}, b[31:0]};
        end
        sr = sub ? (sa - sb) : (sa + sb);
        if (wide) begin
            e.res = sr[63:0];
            e.ovf = sr[64] ^ sr[63];
        end else begin
            e.res = {32'h0, sr[31:0]};
            e.ovf = sr[32] ^ sr[31];
        end
        e.src = src;
        return e;
    endfunction

    task automatic set_req(input bit idx, input logic v, input logic [63:0] a,
                           input logic [63:0] b, input logic s, input logic w);
        if (idx) begin
            bus.r1_valid_i = v; bus.r1_op1_i = a; bus.r1_op2_i = b;
            bus.r1_sub_i = s; bus.r1_wide_i = w;
        end else begin
            bus.r0_valid_i = v; bus.r0_op1_i = a; bus.r0_op2_i = b;
            bus.r0_sub_i = s; bus.r0_wide_i = w;
        end
    endtask

    task automatic idle_inputs();
        set_req(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        set_req(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        bus.o_ready = 1'b1;
        flush_i     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Holds the request until its ready is seen; returns just after the accepting edge.
    task automatic send(input bit idx, input logic [63:0] a, input logic [63:0] b,
                        input logic s, input logic w, output bit ok);
        ok = 1'b0;
        set_req(idx, 1'b1, a, b, s, w);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (idx ? bus.r1_ready_o : bus.r0_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        set_req(idx, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    // Counts cycles after acceptance until o_valid; 0 means it never came.
    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.o_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #13;
        vectors++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid); end
        vectors++; if (bus.o_res !== 64'h0) begin errors++; $display("FAIL reset_res: got %h expected 0", bus.o_res); end
        vectors++; if ({bus.o_ovf, bus.o_src} !== 2'b00) begin errors++; $display("FAIL reset_ovf_src: got %b expected 00", {bus.o_ovf, bus.o_src}); end
        vectors++; if ({bus.r0_ready_o, bus.r1_ready_o} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {bus.r0_ready_o, bus.r1_ready_o}); end
        vectors++; if ({adder_en, adder_op1, adder_op2, adder_cin} !== '0) begin errors++; $display("FAIL reset_adder: got en=%b op1=%h op2=%h expected zero", adder_en, adder_op1, adder_op2); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_narrow_add();
        bit ok; int lat;
        send(1'b0, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, ok);
        vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL narrow_accept: got %b expected 1", ok); end
        wait_rsp(lat);
        vectors++; if (lat !== 2) begin errors++; $display("FAIL narrow_latency: got %0d expected 2", lat); end
        vectors++; if (bus.o_res !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL narrow_res: got %h expected 0000000080000000", bus.o_res); end
        vectors++; if (bus.o_ovf !== 1'b1) begin errors++; $display("FAIL narrow_ovf: got %b expected 1", bus.o_ovf); end
        vectors++; if (bus.o_src !== 1'b0) begin errors++; $display("FAIL narrow_src: got %b expected 0", bus.o_src); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_wide_sub();
        bit ok;
        send(1'b1, 64'h1_0000_0000, 64'h1, 1'b1, 1'b1, ok);
        vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL wide_accept: got %b expected 1", ok); end
        @(negedge clk);
        vectors++; if ({adder_en, adder_cin, adder_op1, adder_op2} !== {1'b1, 1'b1, 33'h0, 33'h0_FFFF_FFFE})
            begin errors++; $display("FAIL wide_lo_beat: got en=%b cin=%b op1=%h op2=%h expected en=1 cin=1 op1=0 op2=0fffffffe", adder_en, adder_cin, adder_op1, adder_op2); end
        @(negedge clk);
        vectors++; if ({adder_en, adder_cin, adder_op1, adder_op2} !== {1'b1, 1'b0, 33'h1, 33'h0_FFFF_FFFF})
            begin errors++; $display("FAIL wide_hi_beat: got en=%b cin=%b op1=%h op2=%h expected en=1 cin=0 op1=1 op2=0ffffffff", adder_en, adder_cin, adder_op1, adder_op2); end
        vectors++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL wide_early_valid: got %b expected 0", bus.o_valid); end
        @(negedge clk);
        vectors++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL wide_valid_c3: got %b expected 1", bus.o_valid); end
        vectors++; if ({bus.o_res, bus.o_ovf, bus.o_src} !== {64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1})
            begin errors++; $display("FAIL wide_result: got res=%h ovf=%b src=%b expected res=00000000ffffffff ovf=0 src=1", bus.o_res, bus.o_ovf, bus.o_src); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_boundary();
        logic [63:0] ta [7] = '{64'h8000_0000, 64'hFFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                                64'h0000_0000_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h0,
                                64'hDEAD_BEEF_0000_0001};
        logic [63:0] tb_ [7] = '{64'h1, 64'h1, 64'h1, 64'h1, 64'h1, 64'h0, 64'hCAFE_F00D_0000_0002};
        logic        ts [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        tw [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bit ok; int lat; bit idx; exp_t e;
        for (int i = 0; i < 7; i++) begin
            idx = 1'($urandom_range(0, 1));
            e = model(ta[i], tb_[i], ts[i], tw[i], idx);
            send(idx, ta[i], tb_[i], ts[i], tw[i], ok);
            wait_rsp(lat);
            vectors++; if (lat !== (tw[i] ? 3 : 2)) begin errors++; $display("FAIL bound%0d_latency: got %0d expected %0d", i, lat, tw[i] ? 3 : 2); end
            vectors++; if ({bus.o_res, bus.o_ovf, bus.o_src} !== e)
                begin errors++; $display("FAIL bound%0d_result: got res=%h ovf=%b src=%b expected res=%h ovf=%b src=%b", i, bus.o_res, bus.o_ovf, bus.o_src, e.res, e.ovf, e.src); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_round_robin();
        exp_t q[$];
        exp_t e, got;
        logic [63:0] a [2], b [2];
        logic s [2], w [2];
        bit exp_g = 1'b0, g, acc, last_wide = 1'b0;
        int rsp = 0, last_cyc = -1;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            a[k] = {$urandom, $urandom}; b[k] = {$urandom, $urandom};
            s[k] = 1'($urandom_range(0, 1)); w[k] = 1'($urandom_range(0, 1));
            set_req(k[0], 1'b1, a[k], b[k], s[k], w[k]);
        end
        for (int cyc = 0; cyc < 200 && rsp < 10; cyc++) begin
            acc = 1'b0;
            g   = 1'b0;
            @(negedge clk);
            if (bus.o_valid) begin
                got = {bus.o_res, bus.o_ovf, bus.o_src};
                e = (q.size() > 0) ? q.pop_front() : '0;
                vectors++; if (got !== e) begin errors++; $display("FAIL rr_result%0d: got res=%h ovf=%b src=%b expected res=%h ovf=%b src=%b", rsp, got.res, got.ovf, got.src, e.res, e.ovf, e.src); end
                rsp++;
            end
            if (bus.r0_ready_o && bus.r1_ready_o) begin
                vectors++; errors++; $display("FAIL rr_both_ready: got 11 expected one-hot");
            end else if (bus.r0_ready_o || bus.r1_ready_o) begin
                g = bus.r1_ready_o;
                acc = 1'b1;
                vectors++; if (g !== exp_g) begin errors++; $display("FAIL rr_grant: got %b expected %b", g, exp_g); end
                if (last_cyc >= 0) begin
                    vectors++; if (cyc - last_cyc !== (last_wide ? 4 : 3)) begin errors++; $display("FAIL rr_throughput: got %0d expected %0d", cyc - last_cyc, last_wide ? 4 : 3); end
                end
                q.push_back(model(a[g], b[g], s[g], w[g], g));
                exp_g = ~g;
                last_cyc = cyc;
                last_wide = w[g];
            end
            @(posedge clk);
            #1;
            if (acc) begin
                a[g] = {$urandom, $urandom}; b[g] = {$urandom, $urandom};
                s[g] = 1'($urandom_range(0, 1)); w[g] = 1'($urandom_range(0, 1));
                set_req(g, 1'b1, a[g], b[g], s[g], w[g]);
            end
        end
        vectors++; if (rsp < 10) begin errors++; $display("FAIL rr_timeout: got %0d responses expected 10", rsp); end
        do_reset();
    endtask

    task automatic test_backpressure();
        bit ok; int lat; exp_t e, e2;
        logic [63:0] a, b, a2, b2;
        logic s, w, s2;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        s = 1'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1));
        e = model(a, b, s, w, 1'b0);
        bus.o_ready = 1'b0;
        send(1'b0, a, b, s, w, ok);
        wait_rsp(lat);
        vectors++; if (lat !== (w ? 3 : 2)) begin errors++; $display("FAIL bp_latency: got %0d expected %0d", lat, w ? 3 : 2); end
        a2 = {32'h0, $urandom}; b2 = {32'h0, $urandom}; s2 = 1'($urandom_range(0, 1));
        e2 = model(a2, b2, s2, 1'b0, 1'b1);
        set_req(1'b1, 1'b1, a2, b2, s2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++; if ({bus.o_valid, bus.o_res, bus.o_ovf, bus.o_src} !== {1'b1, e})
                begin errors++; $display("FAIL bp_hold%0d: got v=%b res=%h ovf=%b src=%b expected v=1 res=%h ovf=%b src=0", i, bus.o_valid, bus.o_res, bus.o_ovf, bus.o_src, e.res, e.ovf); end
            vectors++; if ({bus.r0_ready_o, bus.r1_ready_o} !== 2'b00) begin errors++; $display("FAIL bp_ready%0d: got %b expected 00", i, {bus.r0_ready_o, bus.r1_ready_o}); end
        end
        bus.o_ready = 1'b1;
        #1;
        vectors++; if (bus.r1_ready_o !== 1'b0) begin errors++; $display("FAIL bp_same_cycle_accept: got %b expected 0", bus.r1_ready_o); end
        @(negedge clk);
        vectors++; if ({bus.o_valid, bus.r1_ready_o} !== 2'b01) begin errors++; $display("FAIL bp_next_accept: got valid,ready=%b expected 01", {bus.o_valid, bus.r1_ready_o}); end
        @(posedge clk);
        #1;
        set_req(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        wait_rsp(lat);
        vectors++; if ({bus.o_res, bus.o_ovf, bus.o_src} !== e2)
            begin errors++; $display("FAIL bp_second: got res=%h ovf=%b src=%b expected res=%h ovf=%b src=1", bus.o_res, bus.o_ovf, bus.o_src, e2.res, e2.ovf); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_flush();
        bit ok, seen; int lat; exp_t e;
        logic [63:0] a, b;
        send(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1, ok);
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(negedge clk);
        vectors++; if (adder_en !== 1'b1) begin errors++; $display("FAIL flush_in_hi: got en=%b expected 1", adder_en); end
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.o_valid || adder_en) seen = 1'b1;
        end
        vectors++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_valid: got activity=%b expected 0", seen); end
        flush_i = 1'b1;
        set_req(1'b0, 1'b1, 64'h5, 64'h6, 1'b0, 1'b0);
        #1;
        vectors++; if (bus.r0_ready_o !== 1'b0) begin errors++; $display("FAIL flush_idle_ready: got %b expected 0", bus.r0_ready_o); end
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        set_req(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        a = {32'h0, $urandom}; b = {32'h0, $urandom};
        e = model(a, b, 1'b1, 1'b0, 1'b1);
        send(1'b1, a, b, 1'b1, 1'b0, ok);
        wait_rsp(lat);
        vectors++; if (lat !== 2) begin errors++; $display("FAIL flush_after_latency: got %0d expected 2", lat); end
        vectors++; if ({bus.o_res, bus.o_ovf, bus.o_src} !== e)
            begin errors++; $display("FAIL flush_after_result: got res=%h ovf=%b src=%b expected res=%h ovf=%b src=1", bus.o_res, bus.o_ovf, bus.o_src, e.res, e.ovf); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        bit ok; int lat; exp_t e;
        logic [63:0] a, b;
        send(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b1, ok);
        vectors++; if (adder_en !== 1'b1) begin errors++; $display("FAIL arst_in_lo: got en=%b expected 1", adder_en); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if ({bus.o_valid, adder_en, adder_cin, adder_op1, adder_op2} !== '0)
            begin errors++; $display("FAIL arst_immediate: got v=%b en=%b cin=%b op1=%h op2=%h expected zero", bus.o_valid, adder_en, adder_cin, adder_op1, adder_op2); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        a = {32'h0, $urandom}; b = {32'h0, $urandom};
        e = model(a, b, 1'b0, 1'b0, 1'b0);
        set_req(1'b0, 1'b1, a, b, 1'b0, 1'b0);
        set_req(1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
        @(negedge clk);
        vectors++; if ({bus.r0_ready_o, bus.r1_ready_o} !== 2'b10) begin errors++; $display("FAIL arst_rr_ptr: got %b expected 10", {bus.r0_ready_o, bus.r1_ready_o}); end
        @(posedge clk);
        #1;
        idle_inputs();
        wait_rsp(lat);
        vectors++; if ({bus.o_res, bus.o_ovf, bus.o_src} !== e)
            begin errors++; $display("FAIL arst_after_result: got res=%h ovf=%b src=%b expected res=%h ovf=%b src=0", bus.o_res, bus.o_ovf, bus.o_src, e.res, e.ovf); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_narrow_add();
        test_wide_sub();
        test_boundary();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
